// File: rtl/alarm_sequencer.sv
// Alarm melody sequencer: steps through a fixed 8-note table, driving tone/tone_en
// for a tone_generator, with snooze, stop and optional auto-stop after MAX_LOOPS.
module alarm_sequencer #(
  parameter int unsigned UNIT_CYCLES  = 5000000,
  parameter int unsigned GAP_CYCLES   = 1000000,
  parameter int unsigned SNOOZE_UNITS = 6000,
  parameter int unsigned MAX_LOOPS    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        snooze,
  output logic [21:0] tone,
  output logic        tone_en,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        snoozing,
  output logic        done
);

  localparam longint unsigned SNOOZE_LEN = 64'(SNOOZE_UNITS) * 64'(UNIT_CYCLES);
  localparam longint unsigned NOTE_MAX   = 64'd6 * 64'(UNIT_CYCLES);
  localparam longint unsigned GAP_LEN64  = 64'(GAP_CYCLES);
  localparam longint unsigned MAX_A      = (SNOOZE_LEN > NOTE_MAX) ? SNOOZE_LEN : NOTE_MAX;
  localparam longint unsigned LEN_MAX    = (MAX_A > GAP_LEN64) ? MAX_A : GAP_LEN64;
  localparam int TW = $clog2(LEN_MAX + 64'd1);

  localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_LEN64);
  localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_LEN);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, SNOOZE} state_t;

  function automatic logic [21:0] tbl_tone(input logic [2:0] i);
    case (i)
      3'd0:    return 22'd95602;
      3'd1:    return 22'd75873;
      3'd2:    return 22'd63775;
      3'd3:    return 22'd47755;
      3'd4:    return 22'd0;
      3'd5:    return 22'd63775;
      3'd6:    return 22'd47755;
      default: return 22'd0;
    endcase
  endfunction

  function automatic logic [2:0] tbl_units(input logic [2:0] i);
    case (i)
      3'd3, 3'd6: return 3'd4;
      3'd7:       return 3'd6;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic logic [TW-1:0] note_len(input logic [2:0] i);
    return TW'(64'(tbl_units(i)) * 64'(UNIT_CYCLES));
  endfunction

  state_t          state;
  logic [TW-1:0]   timer;
  logic [7:0]      loops;
  logic [8:0]      loops_next;
  logic            last_loop;
  logic            timer_last;
  logic            running;
  logic            play_go;
  logic [2:0]      play_idx;

  // Timer holds the remaining cycles of the current state, so it expires at 1.
  assign timer_last = (timer == TW'(1));
  assign running    = (state == PLAY) || (state == GAP);
  assign loops_next = {1'b0, loops} + 9'd1;
  assign last_loop  = (MAX_LOOPS != 0) && (loops_next >= 9'(MAX_LOOPS));

  // Every way into PLAY is resolved here so the sequential block loads a note once.
  always_comb begin
    play_go  = 1'b0;
    play_idx = note_idx + 3'd1;
    if (!stop && !(snooze && running)) begin
      case (state)
        IDLE: begin
          play_go  = start;
          play_idx = 3'd0;
        end
        GAP:    play_go = timer_last && !((note_idx == 3'd7) && last_loop);
        SNOOZE: begin
          play_go  = timer_last;
          play_idx = 3'd0;
        end
        default: play_go = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tone     <= '0;
      tone_en  <= 1'b0;
      note_idx <= '0;
      busy     <= 1'b0;
      snoozing <= 1'b0;
      done     <= 1'b0;
      timer    <= '0;
      loops    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        tone     <= '0;
        tone_en  <= 1'b0;
        note_idx <= '0;
        busy     <= 1'b0;
        snoozing <= 1'b0;
        timer    <= '0;
        loops    <= '0;
      end else if (snooze && running) begin
        state    <= SNOOZE;
        timer    <= SNOOZE_LOAD;
        tone_en  <= 1'b0;
        snoozing <= 1'b1;
      end else if (play_go) begin
        state    <= PLAY;
        note_idx <= play_idx;
        tone     <= tbl_tone(play_idx);
        tone_en  <= (tbl_tone(play_idx) != '0);
        timer    <= note_len(play_idx);
        busy     <= 1'b1;
        snoozing <= 1'b0;
        if (state != GAP)
          loops <= '0;
        else if (note_idx == 3'd7)
          loops <= loops_next[7:0];
      end else begin
        case (state)
          PLAY: begin
            if (timer_last) begin
              state   <= GAP;
              timer   <= GAP_LOAD;
              tone_en <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          GAP: begin
            // Only the final-loop expiry reaches here; other expiries went via play_go.
            if (timer_last) begin
              state    <= IDLE;
              tone     <= '0;
              tone_en  <= 1'b0;
              note_idx <= '0;
              busy     <= 1'b0;
              timer    <= '0;
              loops    <= '0;
              done     <= 1'b1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          SNOOZE: timer <= timer - TW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomized bench for alarm_sequencer: two instances (MAX_LOOPS=1 and 0) checked
// every cycle against a melody-position timeline model.
module tb_alarm_sequencer;
  localparam int UC  = 4;
  localparam int GC  = 2;
  localparam int SU  = 10;
  localparam int SNZ = SU * UC;
  localparam int TONES [8] = '{95602, 75873, 63775, 47755, 0, 63775, 47755, 0};
  localparam int UNITS [8] = '{2, 2, 2, 4, 2, 2, 4, 6};
  localparam int MAXL  [2] = '{1, 0};
  localparam int MEL = 24 * UC + 8 * GC;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [21:0] tone_o [2];
  logic        en_o   [2];
  logic [2:0]  idx_o  [2];
  logic        busy_o [2];
  logic        snz_o  [2];
  logic        done_o [2];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: 0 idle, 1 running at melody position m_pos, 2 snoozing
  int m_mode [2], m_pos [2], m_loops [2], m_srem [2];
  int e_tone [2], e_en [2], e_idx [2], e_busy [2], e_snz [2], e_done [2];

  always #5 clk = ~clk;

  alarm_sequencer #(.UNIT_CYCLES(UC), .GAP_CYCLES(GC), .SNOOZE_UNITS(SU), .MAX_LOOPS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .snooze(snooze),
    .tone(tone_o[0]), .tone_en(en_o[0]), .note_idx(idx_o[0]),
    .busy(busy_o[0]), .snoozing(snz_o[0]), .done(done_o[0]));

  alarm_sequencer #(.UNIT_CYCLES(UC), .GAP_CYCLES(GC), .SNOOZE_UNITS(SU), .MAX_LOOPS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .snooze(snooze),
    .tone(tone_o[1]), .tone_en(en_o[1]), .note_idx(idx_o[1]),
    .busy(busy_o[1]), .snoozing(snz_o[1]), .done(done_o[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cycle, got, exp);
    end
  endtask

  task automatic step_model(input int k);
    int acc;
    bit found;
    e_done[k] = 0;
    if (rst || stop) begin
      m_mode[k] = 0; m_pos[k] = 0; m_loops[k] = 0;
    end else if (snooze && m_mode[k] == 1) begin
      m_mode[k] = 2; m_srem[k] = SNZ;
    end else if (start && m_mode[k] == 0) begin
      m_mode[k] = 1; m_pos[k] = 0; m_loops[k] = 0;
    end else if (m_mode[k] == 1) begin
      m_pos[k]++;
      if (m_pos[k] == MEL) begin
        m_loops[k]++;
        if (MAXL[k] != 0 && m_loops[k] >= MAXL[k]) begin
          m_mode[k] = 0; m_loops[k] = 0; e_done[k] = 1;
        end else begin
          m_pos[k] = 0;
        end
      end
    end else if (m_mode[k] == 2) begin
      m_srem[k]--;
      if (m_srem[k] == 0) begin
        m_mode[k] = 1; m_pos[k] = 0; m_loops[k] = 0;
      end
    end

    case (m_mode[k])
      0: begin
        e_tone[k] = 0; e_en[k] = 0; e_idx[k] = 0; e_busy[k] = 0; e_snz[k] = 0;
      end
      1: begin
        acc = 0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
          if (!found && m_pos[k] < acc + UNITS[i] * UC + GC) begin
            found = 1;
            e_idx[k]  = i;
            e_tone[k] = TONES[i];
            e_en[k]   = (m_pos[k] < acc + UNITS[i] * UC && TONES[i] != 0) ? 1 : 0;
          end
          acc += UNITS[i] * UC + GC;
        end
        e_busy[k] = 1; e_snz[k] = 0;
      end
      default: begin
        e_en[k] = 0; e_busy[k] = 1; e_snz[k] = 1;
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    for (int k = 0; k < 2; k++) begin
      step_model(k);
      check($sformatf("tone[%0d]", k),     32'(tone_o[k]), 32'(e_tone[k]));
      check($sformatf("tone_en[%0d]", k),  32'(en_o[k]),   32'(e_en[k]));
      check($sformatf("note_idx[%0d]", k), 32'(idx_o[k]),  32'(e_idx[k]));
      check($sformatf("busy[%0d]", k),     32'(busy_o[k]), 32'(e_busy[k]));
      check($sformatf("snoozing[%0d]", k), 32'(snz_o[k]),  32'(e_snz[k]));
      check($sformatf("done[%0d]", k),     32'(done_o[k]), 32'(e_done[k]));
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Full melody: A auto-stops after one loop, B wraps three times
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3 * MEL + 30) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;

    // Snooze during note 2
    start = 1'b1; cyc(); start = 1'b0;
    repeat (22) cyc();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    repeat (SNZ + 12) cyc();

    // Stop and snooze together during PLAY
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    repeat (3) cyc();

    // Reset mid-GAP of note 5, then restart immediately
    start = 1'b1; cyc(); start = 1'b0;
    repeat (66) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (20) cyc();

    // Randomized control traffic
    repeat (3000) begin
      start  = ($urandom % 20)  == 0;
      snooze = ($urandom % 150) == 0;
      stop   = ($urandom % 300) == 0;
      rst    = ($urandom % 700) == 0;
      cyc();
    end
    start = 1'b0; snooze = 1'b0; rst = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, 5000000, clk cycles per duration unit (50 ms at 100 MHz), >=1.
REQ-002 SHALL have parameter GAP_CYCLES, 1000000, silent clk cycles after every note, >=1.
REQ-003 SHALL have parameter SNOOZE_UNITS, 6000, duration units spent silent in SNOOZE (5 min), >=1.
REQ-004 SHALL have parameter MAX_LOOPS, 0, melody repetitions before auto-stop; 0 = repeat until stop.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level sampled per cycle; begins melody from IDLE.
REQ-008 SHALL have port stop  input  1  terminates any activity.
REQ-009 SHALL have port snooze  input  1  silences melody for snooze interval.
REQ-010 SHALL have port tone  output  22  half-period count, wired directly to tone_generator tone input.
REQ-011 SHALL have port tone_en  output  1  high when buzzer output is to be audible (gates tone_generator sound).
REQ-012 SHALL have port note_idx  output  3  index of current table entry.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port snoozing  output  1  high only in SNOOZE.
REQ-015 SHALL have port done  output  1  single-cycle pulse on auto-stop after MAX_LOOPS.

Function
REQ-016 SHALL hold a fixed 8-entry note table {tone, units}: 0:{95602,2} 1:{75873,2} 2:{63775,2} 3:{47755,4} 4:{0,2} 5:{63775,2} 6:{47755,4} 7:{0,6}; tone 0 = rest.
REQ-017 SHALL implement states IDLE, PLAY, GAP, SNOOZE; all outputs registered.
REQ-018 IDLE with start=1 SHALL enter PLAY next cycle with note_idx=0, loop count 0, tone=table tone, tone_en=1 unless table tone is 0.
REQ-019 PLAY SHALL last exactly units*UNIT_CYCLES cycles, then GAP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with tone_en=0 and tone held; then PLAY at note_idx+1.
REQ-021 After GAP of entry 7, loop count SHALL increment; if MAX_LOOPS=0 or new count<MAX_LOOPS, note_idx wraps to 0 and PLAY; else IDLE with done=1 for that one cycle.
REQ-022 Loop counter SHALL be 8 bits; MAX_LOOPS limited to 0..255.
REQ-023 snooze=1 in PLAY or GAP SHALL enter SNOOZE next cycle: tone_en=0, snoozing=1, timer loaded to SNOOZE_UNITS*UNIT_CYCLES.
REQ-024 SNOOZE expiry SHALL enter PLAY at note_idx=0 with loop count cleared.
REQ-025 snooze in SNOOZE or IDLE SHALL be ignored (timer not restarted).
REQ-026 stop=1 in any state SHALL enter IDLE next cycle: tone_en=0, tone=0, note_idx=0, done=0.
REQ-027 Priority SHALL be rst > stop > snooze > start > timer expiry, when simultaneous.
REQ-028 start while busy SHALL be ignored.
REQ-029 Duration timer SHALL be wide enough for SNOOZE_UNITS*UNIT_CYCLES (>=35 bits default) without wrap.

Reset
REQ-030 rst=1 at posedge SHALL force IDLE, tone=0, tone_en=0, note_idx=0, busy=0, snoozing=0, done=0, timers and loop count 0, regardless of state.
REQ-031 First cycle after rst deassert SHALL honour start.

Verification (UNIT_CYCLES=4, GAP_CYCLES=2, SNOOZE_UNITS=10, MAX_LOOPS=1)
REQ-032 Pulse start -> next cycle tone=95602, tone_en=1 for 8 cycles, tone_en=0 for 2, then tone=75873 for 8.
REQ-033 Run full melody -> total 24 units*4+8*2=112 cycles after start, done=1 one cycle, busy=0; entries 4 and 7 show tone_en=0.
REQ-034 snooze during note 2 -> next cycle snoozing=1, tone_en=0 for 40 cycles, then tone=95602, tone_en=1, note_idx=0.
REQ-035 stop and snooze asserted same cycle during PLAY -> IDLE next cycle, snoozing stays 0.
REQ-036 rst asserted mid-GAP of note 5 -> all outputs zero next cycle; start then replays from note 0.
REQ-037 MAX_LOOPS=0, run 3 melody lengths -> note_idx wraps 7->0 each time, done never asserts.
